// File: rtl/addend_packer_128_pkg.sv
// Shared definitions for the addend packer.
// Contents:
//   - default element width, vector dimension and lanes per beat
//   - derived beats-per-frame and beat counter width
//   - FILL/HOLD state encoding
//   - divisibility helper used by the top-level elaboration check
package addend_packer_128_pkg;

  localparam int unsigned ADDEND_WIDTH = 8;
  localparam int unsigned DIMENTION    = 128;
  localparam int unsigned LANES        = 16;
  localparam int unsigned BEATS        = DIMENTION / LANES;
  localparam int unsigned CNT_WIDTH    = (BEATS > 1) ? $clog2(BEATS) : 1;

  // StFill: accepting beats; StHold: a finished frame waits in the assembly buffer.
  typedef enum logic {
    StFill = 1'b0,
    StHold = 1'b1
  } state_e;

  function automatic bit lanes_divide(input int unsigned dim, input int unsigned lanes);
    return (lanes != 0) && ((dim % lanes) == 0);
  endfunction

endpackage

// File: rtl/addend_packer_128_if.sv
// Stream-in / vector-out bus of the addend packer.
// Signals:
//   in_data        : LANES signed elements, lane j at [j*W +: W]
//   in_valid_n     : beat valid, active-low
//   in_last        : frame-end marker, qualified by in_valid_n == 0
//   in_ready       : beat accepted when in_valid_n == 0 && in_ready == 1
//   addend         : packed DIMENTION-element vector
//   addend_valid_n : vector valid, active-low
//   out_ready      : downstream accepts the vector
//   frame_err      : one-cycle framing-error pulse
// Modports: slave = packer side, master = stream source / vector sink side.
interface addend_packer_128_if
  import addend_packer_128_pkg::*;
#(
  parameter int unsigned ADDEND_WIDTH = addend_packer_128_pkg::ADDEND_WIDTH,
  parameter int unsigned DIMENTION    = addend_packer_128_pkg::DIMENTION,
  parameter int unsigned LANES        = addend_packer_128_pkg::LANES
) ();

  logic [ADDEND_WIDTH*LANES-1:0]     in_data;
  logic                              in_valid_n;
  logic                              in_last;
  logic                              in_ready;
  logic [ADDEND_WIDTH*DIMENTION-1:0] addend;
  logic                              addend_valid_n;
  logic                              out_ready;
  logic                              frame_err;

  modport slave (
    input  in_data,
    input  in_valid_n,
    input  in_last,
    output in_ready,
    output addend,
    output addend_valid_n,
    input  out_ready,
    output frame_err
  );

  modport master (
    output in_data,
    output in_valid_n,
    output in_last,
    input  in_ready,
    input  addend,
    input  addend_valid_n,
    output out_ready,
    input  frame_err
  );

endinterface

// File: rtl/addend_packer_128_beat_deserializer.sv
// Lane-to-vector assembly buffer and beat counter.
// Ports:
//   clk_p, rst_p     : clock, synchronous active-high reset
//   i_beat_fire      : a beat is accepted this cycle
//   i_beat_restart   : accepted beat ends the frame early; next beat is beat 0
//   i_beat_data      : lanes of the accepted beat
//   o_beat_cnt       : index of the beat expected next
//   o_beat_final     : the next accepted beat completes a frame
//   o_asm_vec        : full assembly buffer (valid once a frame is parked in it)
//   o_frame_vec      : buffer with the incoming beat bypassed into the last slot
module addend_packer_128_beat_deserializer
  import addend_packer_128_pkg::*;
#(
  parameter int unsigned ADDEND_WIDTH = addend_packer_128_pkg::ADDEND_WIDTH,
  parameter int unsigned LANES        = addend_packer_128_pkg::LANES,
  parameter int unsigned BEATS        = addend_packer_128_pkg::BEATS,
  parameter int unsigned CNT_WIDTH    = addend_packer_128_pkg::CNT_WIDTH
) (
  input  logic                                  clk_p,
  input  logic                                  rst_p,
  input  logic                                  i_beat_fire,
  input  logic                                  i_beat_restart,
  input  logic [ADDEND_WIDTH*LANES-1:0]         i_beat_data,
  output logic [CNT_WIDTH-1:0]                  o_beat_cnt,
  output logic                                  o_beat_final,
  output logic [ADDEND_WIDTH*LANES*BEATS-1:0]   o_asm_vec,
  output logic [ADDEND_WIDTH*LANES*BEATS-1:0]   o_frame_vec
);

  localparam int unsigned BeatW = ADDEND_WIDTH * LANES;

  logic [CNT_WIDTH-1:0] r_beat_cnt;
  logic [BeatW-1:0]     r_asm [BEATS];
  logic                 w_beat_final;

  assign w_beat_final = (r_beat_cnt == CNT_WIDTH'(BEATS - 1));

  always_ff @(posedge clk_p) begin
    if (rst_p) begin
      r_beat_cnt <= '0;
    end else if (i_beat_fire) begin
      if (w_beat_final || i_beat_restart) begin
        r_beat_cnt <= '0;
      end else begin
        r_beat_cnt <= r_beat_cnt + 1'b1;
      end
    end
  end

  // Contents are don't-care after reset; only the beat counter needs clearing.
  always_ff @(posedge clk_p) begin
    if (i_beat_fire) begin
      r_asm[r_beat_cnt] <= i_beat_data;
    end
  end

  always_comb begin
    o_asm_vec = '0;
    for (int b = 0; b < BEATS; b++) begin
      o_asm_vec[b*BeatW +: BeatW] = r_asm[b];
    end
  end

  // The completing beat goes straight to the output slot without a buffer round trip.
  always_comb begin
    o_frame_vec = o_asm_vec;
    o_frame_vec[(BEATS-1)*BeatW +: BeatW] = i_beat_data;
  end

  assign o_beat_cnt   = r_beat_cnt;
  assign o_beat_final = w_beat_final;

endmodule

// File: rtl/addend_packer_128.sv
// Transmit-side front end for the 128-input adder tree.
// Collects LANES-element beats into one DIMENTION-element vector and presents it with an
// active-low valid. Double-buffered: a finished frame may wait in the assembly buffer
// (HOLD) while the previous vector sits in the output slot.
// Ports:
//   clk_p : clock, rising edge
//   rst_p : synchronous reset, active-high
//   bus   : slave view of addend_packer_128_if (beat stream in, vector out, frame_err)
module addend_packer_128
  import addend_packer_128_pkg::*;
#(
  parameter int unsigned ADDEND_WIDTH = addend_packer_128_pkg::ADDEND_WIDTH,
  parameter int unsigned DIMENTION    = addend_packer_128_pkg::DIMENTION,
  parameter int unsigned LANES        = addend_packer_128_pkg::LANES
) (
  input  logic                clk_p,
  input  logic                rst_p,
  addend_packer_128_if.slave  bus
);

  localparam int unsigned BEATS     = DIMENTION / LANES;
  localparam int unsigned CNT_WIDTH = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned VecW      = ADDEND_WIDTH * DIMENTION;

  if (!lanes_divide(DIMENTION, LANES)) begin : g_bad_lanes
    $error("DIMENTION must be an exact multiple of LANES");
  end

  state_e               r_state;
  state_e               w_state_d;
  logic [VecW-1:0]      r_addend;
  logic [VecW-1:0]      w_addend_d;
  logic                 r_addend_valid_n;
  logic                 w_addend_valid_n_d;
  logic                 r_frame_err;
  logic                 w_frame_err_d;

  logic                 w_in_ready;
  logic                 w_fire;
  logic                 w_complete;
  logic                 w_early_last;
  logic                 w_slot_free;
  logic [CNT_WIDTH-1:0] w_beat_cnt;
  logic                 w_beat_final;
  logic [VecW-1:0]      w_asm_vec;
  logic [VecW-1:0]      w_frame_vec;

  assign w_in_ready   = !rst_p && (r_state == StFill);
  assign w_fire       = !bus.in_valid_n && w_in_ready;
  assign w_complete   = w_fire && w_beat_final;
  assign w_early_last = w_fire && bus.in_last && !w_beat_final;
  // Slot is free if empty now or being drained at this edge.
  assign w_slot_free  = r_addend_valid_n || bus.out_ready;

  addend_packer_128_beat_deserializer #(
    .ADDEND_WIDTH (ADDEND_WIDTH),
    .LANES        (LANES),
    .BEATS        (BEATS),
    .CNT_WIDTH    (CNT_WIDTH)
  ) u_deser (
    .clk_p          (clk_p),
    .rst_p          (rst_p),
    .i_beat_fire    (w_fire),
    .i_beat_restart (w_early_last),
    .i_beat_data    (bus.in_data),
    .o_beat_cnt     (w_beat_cnt),
    .o_beat_final   (w_beat_final),
    .o_asm_vec      (w_asm_vec),
    .o_frame_vec    (w_frame_vec)
  );

  always_comb begin
    w_state_d          = r_state;
    w_addend_d         = r_addend;
    // A transfer empties the slot; a load below re-asserts valid in the same edge.
    w_addend_valid_n_d = r_addend_valid_n || bus.out_ready;
    w_frame_err_d      = 1'b0;
    unique case (r_state)
      StFill: begin
        if (w_complete) begin
          w_frame_err_d = !bus.in_last;
          if (w_slot_free) begin
            w_addend_d         = w_frame_vec;
            w_addend_valid_n_d = 1'b0;
          end else begin
            w_state_d = StHold;
          end
        end else if (w_early_last) begin
          w_frame_err_d = 1'b1;
        end
      end
      StHold: begin
        if (w_slot_free) begin
          w_addend_d         = w_asm_vec;
          w_addend_valid_n_d = 1'b0;
          w_state_d          = StFill;
        end
      end
      default: w_state_d = StFill;
    endcase
  end

  always_ff @(posedge clk_p) begin
    if (rst_p) begin
      r_state          <= StFill;
      r_addend         <= '0;
      r_addend_valid_n <= 1'b1;
      r_frame_err      <= 1'b0;
    end else begin
      r_state          <= w_state_d;
      r_addend         <= w_addend_d;
      r_addend_valid_n <= w_addend_valid_n_d;
      r_frame_err      <= w_frame_err_d;
    end
  end

  assign bus.in_ready       = w_in_ready;
  assign bus.addend         = r_addend;
  assign bus.addend_valid_n = r_addend_valid_n;
  assign bus.frame_err      = r_frame_err;

  logic w_unused;
  assign w_unused = ^w_beat_cnt;

endmodule

// File: tb/tb_addend_packer_128.sv
// Scoreboard bench for addend_packer_128: the stimulus side feeds an element-list model
// that pushes expected vectors; a negedge monitor pops and compares on each transfer.
module tb_addend_packer_128;

  localparam int W  = 8;
  localparam int D  = 128;
  localparam int L  = 16;
  localparam int NB = D / L;

  logic clk;
  logic rst;

  addend_packer_128_if bus ();

  addend_packer_128 dut (
    .clk_p (clk),
    .rst_p (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  logic [W*D-1:0] exp_q [$];
  logic [W-1:0]   cur   [$];
  int             xfer_q [$];
  logic [W*D-1:0] last_vec;
  int             low_cycles = 0;
  int             err_seen   = 0;
  int             err_exp    = 0;
  int             stall_cnt  = 0;
  int             acc_cyc    = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic vcheck(input string name, input logic [W*D-1:0] act,
                        input logic [W*D-1:0] exp);
    int idx;
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      idx = 0;
      for (int i = D - 1; i >= 0; i--) begin
        if (act[i*W +: W] !== exp[i*W +: W]) idx = i;
      end
      $display("FAIL %s: element %0d got %h, expected %h", name, idx,
               act[idx*W +: W], exp[idx*W +: W]);
    end
  endtask

  // Reference model: an accepted beat appends its elements to the current frame.
  task automatic model_accept(input logic [W*L-1:0] data, input bit last);
    logic [W*D-1:0] v;
    for (int j = 0; j < L; j++) cur.push_back(data[j*W +: W]);
    if (cur.size() == D) begin
      for (int i = 0; i < D; i++) v[i*W +: W] = cur[i];
      exp_q.push_back(v);
      if (!last) err_exp++;
      cur.delete();
    end else if (last) begin
      err_exp++;
      cur.delete();
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat is taken.
  task automatic send_beat(input logic [W*L-1:0] data, input bit last);
    int waitc;
    bus.in_data    = data;
    bus.in_valid_n = 1'b0;
    bus.in_last    = last;
    waitc = 0;
    @(negedge clk);
    while (!bus.in_ready && waitc < 200) begin
      waitc++;
      stall_cnt++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL beat_accept_timeout: in_ready got 0, expected 1 within 200 cycles");
    end else begin
      model_accept(data, last);
      acc_cyc = cyc + 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.in_valid_n = 1'b1;
    bus.in_last    = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [W*L-1:0] rand_beat();
    logic [W*L-1:0] d;
    for (int k = 0; k < (W * L) / 32; k++) d[k*32 +: 32] = $urandom;
    return d;
  endfunction

  // Monitor: sees the cycle's settled outputs at negedge; transfer happens at next edge.
  logic prev_valid_n = 1'b1;
  always @(negedge clk) begin
    if (!rst && bus.addend_valid_n === 1'b0) begin
      low_cycles++;
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_vector: addend_valid_n got 0, expected 1 (no frame due)");
      end else begin
        vcheck("addend", bus.addend, exp_q[0]);
        if (bus.out_ready) begin
          last_vec = bus.addend;
          void'(exp_q.pop_front());
          xfer_q.push_back(cyc);
        end
      end
    end
    if (!rst && bus.frame_err === 1'b1) err_seen++;
    prev_valid_n = bus.addend_valid_n;
  end

  initial begin
    logic [W*L-1:0] d;
    int             e0;
    int             x0;

    rst            = 1'b1;
    bus.in_data    = '0;
    bus.in_valid_n = 1'b1;
    bus.in_last    = 1'b0;
    bus.out_ready  = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_valid_n", int'(bus.addend_valid_n), 1);
    vcheck("reset_addend", bus.addend, '0);
    check("reset_in_ready", int'(bus.in_ready), 0);
    check("reset_frame_err", int'(bus.frame_err), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single frame, element i = i - 64.
    xfer_q.delete();
    low_cycles = 0;
    for (int b = 0; b < NB; b++) begin
      for (int j = 0; j < L; j++) d[j*W +: W] = W'(b * L + j - 64);
      send_beat(d, b == NB - 1);
    end
    idle(4);
    check("single_xfers", xfer_q.size(), 1);
    if (xfer_q.size() > 0) check("single_latency", xfer_q[0], acc_cyc);
    check("single_valid_low_cycles", low_cycles, 1);
    check("single_elem0", int'(last_vec[7:0]), 8'hC0);
    check("single_elem127", int'(last_vec[W*D-1 -: 8]), 8'h3F);

    // Back-to-back frames, 24 consecutive beats.
    xfer_q.delete();
    stall_cnt = 0;
    for (int b = 0; b < 3 * NB; b++) send_beat(rand_beat(), (b % NB) == NB - 1);
    idle(4);
    check("b2b_stalls", stall_cnt, 0);
    check("b2b_xfers", xfer_q.size(), 3);
    for (int i = 1; i < xfer_q.size(); i++) check("b2b_spacing", xfer_q[i] - xfer_q[i-1], 8);
    check("b2b_drained", exp_q.size(), 0);

    // Backpressure: out_ready low for 20 cycles while two frames arrive.
    xfer_q.delete();
    bus.out_ready = 1'b0;
    for (int b = 0; b < 2 * NB; b++) send_beat(rand_beat(), (b % NB) == NB - 1);
    idle(4);
    @(negedge clk);
    check("bp_in_ready_hold", int'(bus.in_ready), 0);
    check("bp_valid_held", int'(bus.addend_valid_n), 0);
    check("bp_no_xfer", xfer_q.size(), 0);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    idle(4);
    check("bp_xfers", xfer_q.size(), 2);
    if (xfer_q.size() == 2) check("bp_consecutive", xfer_q[1] - xfer_q[0], 1);
    check("bp_drained", exp_q.size(), 0);
    @(negedge clk);
    check("bp_in_ready_back", int'(bus.in_ready), 1);
    @(posedge clk);
    #1;

    // Early last on beat 3, then a clean frame.
    e0 = err_seen;
    xfer_q.delete();
    for (int b = 0; b < 4; b++) send_beat(rand_beat(), b == 3);
    idle(4);
    check("early_err_pulses", err_seen - e0, 1);
    check("early_no_vector", xfer_q.size(), 0);
    for (int b = 0; b < NB; b++) begin
      for (int j = 0; j < L; j++) d[j*W +: W] = W'(b * L + j) ^ 8'h5A;
      send_beat(d, b == NB - 1);
    end
    idle(4);
    check("early_next_xfers", xfer_q.size(), 1);
    check("early_next_elem0", int'(last_vec[7:0]), 8'h5A);
    check("early_next_elem1", int'(last_vec[15:8]), 8'h5B);

    // Missing last.
    e0 = err_seen;
    x0 = xfer_q.size();
    for (int b = 0; b < NB; b++) send_beat(rand_beat(), 1'b0);
    idle(4);
    check("missing_xfers", xfer_q.size() - x0, 1);
    check("missing_err_pulses", err_seen - e0, 1);

    // Reset after beat 5 of a frame.
    x0 = xfer_q.size();
    for (int b = 0; b < 6; b++) send_beat(rand_beat(), 1'b0);
    bus.in_valid_n = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", int'(bus.in_ready), 0);
    @(posedge clk);
    #1;
    cur.delete();
    @(negedge clk);
    check("midrst_valid_n", int'(bus.addend_valid_n), 1);
    vcheck("midrst_addend", bus.addend, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int b = 0; b < NB; b++) begin
      for (int j = 0; j < L; j++) d[j*W +: W] = W'(b * L + j + 1);
      send_beat(d, b == NB - 1);
    end
    idle(4);
    check("midrst_xfers", xfer_q.size() - x0, 1);
    check("midrst_elem0", int'(last_vec[7:0]), 8'h01);

    check("total_frame_err", err_seen, err_exp);
    check("final_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time got 200000, expected completion earlier");
    $fatal(1, "timeout");
  end

endmodule
